vga_text_reader: RTL
====================

Name: vga_text_reader

Overview:
- Read-side counterpart of the CPU-side video RAM write port.
- Scans the 80x25 text buffer in video RAM and looks up glyph rows in an external 8x16 font ROM.
- Drives 640x480@60 VGA timing and colour, with text in lines 0-399 and black in lines 400-479.
- Each video RAM word is {attr[15:8], char[7:0]}. attr[3:0] is the foreground colour (IRGB) and attr[7:4] is the background colour (IRGB).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- TEXT_COLS, 80, character columns
- TEXT_ROWS, 25, character rows (16 lines each)

Ports:
- clk  in  1  pixel clock (25 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- video_ram_addr  out  12  cell index, row*80+col
- video_ram_data  in  16  {attr, char}, valid 1 clk after address
- font_addr  out  12  {char[7:0], glyph_line[3:0]}
- font_data  in  8  glyph row, valid 1 clk after address; bit7 = leftmost pixel
- vga_hsync  out  1  active low
- vga_vsync  out  1  active low
- vga_r  out  2  red
- vga_g  out  2  green
- vga_b  out  2  blue
- frame_start  out  1  1-clk pulse when h=0,v=0 enters stage 0

Behaviour:
- Reset values (asynchronous):
  - h_cnt=0, v_cnt=0, row_base=0
  - all pipeline registers cleared
  - vga_hsync=1, vga_vsync=1, rgb=0, frame_start=0
  - video_ram_addr=0, font_addr=0
- Counters:
  - h_cnt counts 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it counts 0..524 and wraps to 0.
- Text area: h_cnt<640 and v_cnt<400. col=h_cnt[9:3], glyph_line=v_cnt[3:0].
- row_base:
  - Holds the current text row times 80. No multiplier.
  - Cleared at v wrap.
  - Increments by 80 at the line wrap where v_cnt[3:0]==15 and v_cnt<400.
- Stage 0 (registered): video_ram_addr <= row_base + col in the text area, else 0. Also latches h[2:0], text_active, raw syncs, and frame_start.
- Stage 1: font_addr <= {video_ram_data[7:0], glyph_line}. attr is latched.
- Stage 2: font_data is valid. Pixel bit = font_data[7 - h[2:0]], using h[2:0] delayed 2 stages.
- Stage 3 (output register):
  - colour = bit ? attr[3:0] : attr[7:4]
  - Colour is forced to 0 when text_active is false (includes v 400-479 and blanking).
- Colour mapping per channel (channel bit c, intensity i = IRGB[3]): c=0,i=0 -> 00; c=0,i=1 -> 01; c=1,i=0 -> 10; c=1,i=1 -> 11.
- Sync timing:
  - Raw hsync low for h_cnt 656..751.
  - Raw vsync low for v_cnt 490..491.
  - Both syncs are delayed through the same 3 pipeline stages, so all outputs share one latency.
- Latency: the pixel for counter value (h,v) appears on vga_r/g/b exactly 4 clk after the counters hold (h,v) (stage 0 register plus 3 stages). Syncs and frame_start are aligned to the same latency.
- No read handshake: video RAM and font ROM are assumed single-cycle synchronous, and the reader never stalls.
- Concurrent CPU writes to the same cell are permitted. The value seen is whatever the RAM returns (tearing allowed).
- Reset mid-frame: all state returns to reset values immediately. Scanning restarts at (0,0) on the first clk after rst falls.

Decomposition:
- Shared package `video_pkg` holds:
  - VGA timing constants
  - TEXT_COLS/TEXT_ROWS
  - VRAM base 0xF82F
  - the IRGB-to-2-bit channel function
- One natural sub-module, `vga_timing`: h/v counters, raw syncs, active flags, frame_start.
- The pipeline and colour stage stay in the top module.

Test Plan:
- Reset: assert rst mid-line -> hsync=vsync=1, rgb=0, video_ram_addr=0 immediately (async). Release -> frame_start pulses 4 clk later.
- Timing: free-run one frame -> hsync low 96 clk of every 800, vsync low for 2 lines of 525. Hsync falling edge occurs 656+4 clk after frame_start-referenced h=0.
- Addressing:
  - video_ram_addr=0 at (0,0), =79 at h=632, =80 at (0,16).
  - =1999 at (632,384).
  - row_base returns to 0 after v wrap.
- Glyph/colour:
  - Setup: VRAM[0]=0x0759, font model returns 0x80 for {0x59, line}.
  - At h=0: font_addr={0x59, v[3:0]}; rgb=(10,10,10) white-ish for h=0.
  - h=1..7: rgb=0 (bg black).
  - With VRAM[0]=0x1F41: fg=bright white (11,11,11), bg=blue (00,00,10).
- Blank region: any VRAM content, v=400..479 -> rgb=0 throughout. Same for h>=640.
- Latency alignment: VRAM[1]=0x0C00, font=0xFF -> bright red (11,00,00) appears for exactly 8 clk, starting 4 clk after h_cnt=8.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and helpers for the text-mode video reader.
package video_pkg;

  // 640x480@60 timing
  localparam int unsigned HActive  = 640;
  localparam int unsigned HFp      = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HBp      = 48;
  localparam int unsigned VActive  = 480;
  localparam int unsigned VFp      = 10;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VBp      = 33;

  // Text buffer geometry (8x16 glyph cells)
  localparam int unsigned TextCols = 80;
  localparam int unsigned TextRows = 25;

  // CPU-side base address of the text buffer
  localparam logic [15:0] VramBase = 16'hF82F;

  // Per-pixel control bits carried down the read pipeline
  typedef struct packed {
    logic [2:0] h_fine;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       frame;
  } pipe_ctl_t;

  // One IRGB colour bit plus intensity mapped to a 2-bit DAC channel
  function automatic logic [1:0] irgb_chan(input logic c, input logic i);
    return {c, i};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters and raw per-pixel timing flags.
module vga_timing
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = HActive,
  parameter int unsigned H_FP      = HFp,
  parameter int unsigned H_SYNC    = HSync,
  parameter int unsigned H_BP      = HBp,
  parameter int unsigned V_ACTIVE  = VActive,
  parameter int unsigned V_FP      = VFp,
  parameter int unsigned V_SYNC    = VSync,
  parameter int unsigned V_BP      = VBp,
  parameter int unsigned TEXT_COLS = TextCols,
  parameter int unsigned TEXT_ROWS = TextRows
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [9:0] h_nxt_o,
  output logic [9:0] v_nxt_o,
  output logic [2:0] h_fine_o,
  output logic [3:0] v_line_o,
  output logic       row_step_o,
  output logic       frame_wrap_o,
  output logic       text_active_o,
  output logic       hsync_raw_o,
  output logic       vsync_raw_o,
  output logic       frame_start_o
);

  localparam logic [9:0] HLast     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VLast     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HSyncLo   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncHi   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncLo   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncHi   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] TextWidth = 10'(TEXT_COLS * 8);
  localparam logic [9:0] TextLines = 10'(TEXT_ROWS * 16);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       line_wrap;

  // Next counter values; exported so the address stage can work one pixel ahead.
  always_comb begin
    line_wrap    = (h_q == HLast);
    frame_wrap_o = line_wrap && (v_q == VLast);
    h_d          = line_wrap ? 10'd0 : h_q + 10'd1;
    v_d          = v_q;
    if (line_wrap) begin
      v_d = frame_wrap_o ? 10'd0 : v_q + 10'd1;
    end
  end

  // Scan counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Raw flags for the pixel the counters currently hold (syncs active-high here).
  always_comb begin
    h_nxt_o       = h_d;
    v_nxt_o       = v_d;
    h_fine_o      = h_q[2:0];
    v_line_o      = v_q[3:0];
    row_step_o    = line_wrap && (v_q[3:0] == 4'hF) && (v_q < TextLines);
    text_active_o = (h_q < TextWidth) && (v_q < TextLines);
    hsync_raw_o   = (h_q >= HSyncLo) && (h_q < HSyncHi);
    vsync_raw_o   = (v_q >= VSyncLo) && (v_q < VSyncHi);
    frame_start_o = (h_q == 10'd0) && (v_q == 10'd0);
  end

endmodule

// File: rtl/vga_text_reader.sv
// Text-mode VGA scan-out: video RAM -> font ROM -> colour, 4-clk fixed latency.
module vga_text_reader
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = HActive,
  parameter int unsigned H_FP      = HFp,
  parameter int unsigned H_SYNC    = HSync,
  parameter int unsigned H_BP      = HBp,
  parameter int unsigned V_ACTIVE  = VActive,
  parameter int unsigned V_FP      = VFp,
  parameter int unsigned V_SYNC    = VSync,
  parameter int unsigned V_BP      = VBp,
  parameter int unsigned TEXT_COLS = TextCols,
  parameter int unsigned TEXT_ROWS = TextRows
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] video_ram_addr,
  input  logic [15:0] video_ram_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [1:0]  vga_r,
  output logic [1:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        frame_start
);

  localparam logic [9:0]  TextWidth = 10'(TEXT_COLS * 8);
  localparam logic [9:0]  TextLines = 10'(TEXT_ROWS * 16);
  localparam logic [11:0] RowStep   = 12'(TEXT_COLS);

  logic [9:0]  h_nxt, v_nxt;
  logic [2:0]  h_fine;
  logic [3:0]  v_line;
  logic        row_step, frame_wrap;
  logic        text_active, hsync_raw, vsync_raw, frame_raw;

  logic [11:0] row_base_q, row_base_d;
  logic [11:0] addr_d;
  pipe_ctl_t   s0_d, s0_q, s1_q, s2_q;
  logic [3:0]  glyph_line_q;
  logic [7:0]  attr1_q, attr2_q;
  logic        pix_bit;
  logic [3:0]  irgb;
  logic [5:0]  rgb_d;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .TEXT_COLS(TEXT_COLS),
    .TEXT_ROWS(TEXT_ROWS)
  ) u_timing (
    .clk_i        (clk),
    .rst_i        (rst),
    .h_nxt_o      (h_nxt),
    .v_nxt_o      (v_nxt),
    .h_fine_o     (h_fine),
    .v_line_o     (v_line),
    .row_step_o   (row_step),
    .frame_wrap_o (frame_wrap),
    .text_active_o(text_active),
    .hsync_raw_o  (hsync_raw),
    .vsync_raw_o  (vsync_raw),
    .frame_start_o(frame_raw)
  );

  // Row base (text row * cols, by repeated addition) and the cell address for the
  // next pixel, so the RAM read completes in step with the control pipeline.
  always_comb begin
    row_base_d = row_base_q;
    if (frame_wrap) begin
      row_base_d = '0;
    end else if (row_step) begin
      row_base_d = row_base_q + RowStep;
    end
    addr_d = '0;
    if ((h_nxt < TextWidth) && (v_nxt < TextLines)) begin
      addr_d = row_base_d + 12'(h_nxt[9:3]);
    end
    s0_d.h_fine = h_fine;
    s0_d.active = text_active;
    s0_d.hsync  = hsync_raw;
    s0_d.vsync  = vsync_raw;
    s0_d.frame  = frame_raw;
  end

  // Stage 0: video RAM address, row base and per-pixel control capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      video_ram_addr <= '0;
      row_base_q     <= '0;
      s0_q           <= '0;
      glyph_line_q   <= '0;
    end else begin
      video_ram_addr <= addr_d;
      row_base_q     <= row_base_d;
      s0_q           <= s0_d;
      glyph_line_q   <= v_line;
    end
  end

  // Stage 1: character code from RAM selects the glyph row; attribute latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      font_addr <= '0;
      attr1_q   <= '0;
      s1_q      <= '0;
    end else begin
      font_addr <= {video_ram_data[7:0], glyph_line_q};
      attr1_q   <= video_ram_data[15:8];
      s1_q      <= s0_q;
    end
  end

  // Stage 2: hold control and attribute while the font ROM read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attr2_q <= '0;
      s2_q    <= '0;
    end else begin
      attr2_q <= attr1_q;
      s2_q    <= s1_q;
    end
  end

  // Pixel select and IRGB expansion; anything outside the text area is black.
  always_comb begin
    pix_bit = font_data[3'd7 - s2_q.h_fine];
    irgb    = pix_bit ? attr2_q[3:0] : attr2_q[7:4];
    rgb_d   = '0;
    if (s2_q.active) begin
      rgb_d = {irgb_chan(irgb[2], irgb[3]), irgb_chan(irgb[1], irgb[3]),
               irgb_chan(irgb[0], irgb[3])};
    end
  end

  // Stage 3: output register for colour, syncs (active low) and frame marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb_d;
      vga_hsync   <= ~s2_q.hsync;
      vga_vsync   <= ~s2_q.vsync;
      frame_start <= s2_q.frame;
    end
  end

endmodule
